// File: rtl/qbert_move_scheduler_if.sv
// rtl/qbert_move_scheduler_if.sv - command, qbert-layer and status signals of the move scheduler
interface qbert_move_scheduler_if #(
  parameter int N_cube = 6
);
  logic              restart;
  logic              cmd_valid;
  logic [2:0]        cmd_dir;
  logic              cmd_ready;
  logic              done_move;
  logic [2:0]        qbert_jump;
  logic              nios_start_qbert;
  logic              bad_jump;
  logic [N_cube-1:0] top_color;
  logic [2:0]        qbert_rank;
  logic [2:0]        qbert_col;
  logic              level_done;
  logic              fell;
  logic              timeout_err;

  modport master (
    output restart, cmd_valid, cmd_dir, done_move,
    input  cmd_ready, qbert_jump, nios_start_qbert, bad_jump,
    input  top_color, qbert_rank, qbert_col, level_done, fell, timeout_err
  );

  modport slave (
    input  restart, cmd_valid, cmd_dir, done_move,
    output cmd_ready, qbert_jump, nios_start_qbert, bad_jump,
    output top_color, qbert_rank, qbert_col, level_done, fell, timeout_err
  );
endinterface

// File: rtl/qbert_move_scheduler.sv
// rtl/qbert_move_scheduler.sv - sequences Q*bert jumps on the pyramid and tracks visited cubes
module qbert_move_scheduler #(
  parameter int N_rank  = 3,
  parameter int N_cube  = 6,
  parameter int TIMEOUT = 2000000
) (
  input  logic                  CLK_33,
  input  logic                  reset,
  qbert_move_scheduler_if.slave bus
);

  localparam int                CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic signed [3:0] RANK_MAX = 4'(N_rank - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_LAND,
    S_FALLEN,
    S_ERROR
  } state_t;

  state_t state, state_n;

  logic [2:0]        rank_r, col_r;
  logic [2:0]        tgt_rank, tgt_col;
  logic [4:0]        tgt_idx;
  logic              bad_r;
  logic [2:0]        jump_r;
  logic              bad_out_r;
  logic [N_cube-1:0] top_color_r;
  logic              level_done_r, fell_r, timeout_r;
  logic [CW-1:0]     to_cnt;
  logic              done_d, done_d2, done_rise;

  logic signed [3:0] dr, dc, tr, tc;
  logic              oob, dir_legal, accept;
  logic              cmd_ready_c, start_c;
  logic [N_cube-1:0] colour_set, colour_next;

  // First visible triangle number of each rank; index = base(rank) + col
  function automatic logic [4:0] cube_index(input logic [2:0] r, input logic [2:0] c);
    logic [4:0] base;
    case (r)
      3'd0:    base = 5'd0;
      3'd1:    base = 5'd1;
      3'd2:    base = 5'd3;
      3'd3:    base = 5'd6;
      3'd4:    base = 5'd10;
      3'd5:    base = 5'd15;
      3'd6:    base = 5'd21;
      default: base = 5'd28;
    endcase
    return base + {2'b00, c};
  endfunction

  // done_move may be a level; only its rising edge ends a move
  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      done_d  <= 1'b0;
      done_d2 <= 1'b0;
    end else begin
      done_d  <= bus.done_move;
      done_d2 <= done_d;
    end
  end

  assign done_rise = done_d & ~done_d2;

  always_comb begin
    dr = 4'sd0;
    dc = 4'sd0;
    case (bus.cmd_dir)
      3'd1: dr = -4'sd1;
      3'd2: begin dr = -4'sd1; dc = -4'sd1; end
      3'd3: begin dr = 4'sd1;  dc = 4'sd1;  end
      3'd4: dr = 4'sd1;
      default: ;
    endcase
    tr  = $signed({1'b0, rank_r}) + dr;
    tc  = $signed({1'b0, col_r}) + dc;
    oob = (tr < 4'sd0) || (tr > RANK_MAX) || (tc < 4'sd0) || (tc > tr);
  end

  assign dir_legal = bus.cmd_dir inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign accept    = (state == S_IDLE) && bus.cmd_valid && !bus.restart
                     && !level_done_r && dir_legal;

  always_comb begin
    colour_set = '0;
    for (int i = 0; i < N_cube; i++) begin
      colour_set[i] = (tgt_idx == 5'(i));
    end
    colour_next = top_color_r | colour_set;
  end

  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.restart) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_n = S_LAUNCH;
        S_LAUNCH: state_n = S_WAIT;
        S_WAIT: begin
          if (done_rise)              state_n = S_LAND;
          else if (to_cnt == TO_LAST) state_n = S_ERROR;
        end
        S_LAND:   state_n = bad_r ? S_FALLEN : S_IDLE;
        default:  state_n = state;
      endcase
    end
  end

  always_comb begin
    cmd_ready_c = (state == S_IDLE);
    start_c     = (state == S_LAUNCH);
  end

  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      rank_r       <= '0;
      col_r        <= '0;
      tgt_rank     <= '0;
      tgt_col      <= '0;
      tgt_idx      <= '0;
      bad_r        <= 1'b0;
      jump_r       <= '0;
      bad_out_r    <= 1'b0;
      top_color_r  <= N_cube'(1);
      level_done_r <= 1'b0;
      fell_r       <= 1'b0;
      timeout_r    <= 1'b0;
      to_cnt       <= '0;
    end else if (bus.restart) begin
      rank_r       <= '0;
      col_r        <= '0;
      bad_r        <= 1'b0;
      jump_r       <= '0;
      bad_out_r    <= 1'b0;
      top_color_r  <= N_cube'(1);
      level_done_r <= 1'b0;
      fell_r       <= 1'b0;
      timeout_r    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      if (accept) begin
        tgt_rank  <= tr[2:0];
        tgt_col   <= tc[2:0];
        tgt_idx   <= cube_index(tr[2:0], tc[2:0]);
        bad_r     <= oob;
        jump_r    <= bus.cmd_dir;
        bad_out_r <= oob;
      end
      if (state == S_LAUNCH) begin
        to_cnt <= '0;
      end
      if (state == S_WAIT) begin
        to_cnt <= to_cnt + CW'(1);
        if (!done_rise && to_cnt == TO_LAST) timeout_r <= 1'b1;
      end
      if (state == S_LAND) begin
        if (bad_r) begin
          fell_r <= 1'b1;
        end else begin
          rank_r      <= tgt_rank;
          col_r       <= tgt_col;
          top_color_r <= colour_next;
          bad_out_r   <= 1'b0;
          if (&colour_next) level_done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready        = cmd_ready_c;
  assign bus.nios_start_qbert = start_c;
  assign bus.qbert_jump       = jump_r;
  assign bus.bad_jump         = bad_out_r;
  assign bus.top_color        = top_color_r;
  assign bus.qbert_rank       = rank_r;
  assign bus.qbert_col        = col_r;
  assign bus.level_done       = level_done_r;
  assign bus.fell             = fell_r;
  assign bus.timeout_err      = timeout_r;

endmodule

// File: tb/tb_qbert_move_scheduler.sv
// tb/tb_qbert_move_scheduler.sv - directed and randomized checks of the move scheduler against a pyramid model
module tb_qbert_move_scheduler;
  localparam int NR = 3;
  localparam int NC = 6;
  localparam int TO = 16;

  logic CLK_33 = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  qbert_move_scheduler_if #(.N_cube(NC)) bus();

  qbert_move_scheduler #(.N_rank(NR), .N_cube(NC), .TIMEOUT(TO)) dut (
    .CLK_33 (CLK_33),
    .reset  (reset),
    .bus    (bus)
  );

  always #15 CLK_33 = ~CLK_33;

  int m_r, m_c, m_jump;
  bit m_vis [NC];
  bit m_level, m_fell, m_to, m_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_33);
    #1;
  endtask

  task automatic model_reset();
    m_r = 0; m_c = 0; m_jump = 0;
    for (int i = 0; i < NC; i++) m_vis[i] = (i == 0);
    m_level = 0; m_fell = 0; m_to = 0; m_bad = 0;
  endtask

  function automatic logic [31:0] exp_colour();
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < NC; i++) if (m_vis[i]) v = v | (32'd1 << i);
    return v;
  endfunction

  function automatic void target(input int dir, output int tr, output int tc);
    tr = m_r;
    tc = m_c;
    case (dir)
      1: tr = tr - 1;
      2: begin tr = tr - 1; tc = tc - 1; end
      3: begin tr = tr + 1; tc = tc + 1; end
      4: tr = tr + 1;
      default: ;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rank"},   bus.qbert_rank, m_r);
    check({tag, ".col"},    bus.qbert_col, m_c);
    check({tag, ".colour"}, bus.top_color, exp_colour());
    check({tag, ".level"},  bus.level_done, m_level);
    check({tag, ".fell"},   bus.fell, m_fell);
    check({tag, ".tmo"},    bus.timeout_err, m_to);
    check({tag, ".bad"},    bus.bad_jump, m_bad);
    check({tag, ".jump"},   bus.qbert_jump, m_jump);
    check({tag, ".ready"},  bus.cmd_ready, !(m_fell || m_to));
    check({tag, ".start"},  bus.nios_start_qbert, 0);
  endtask

  task automatic do_move(input int dir);
    int tr, tc;
    bit oob, all;
    target(dir, tr, tc);
    oob = (tr < 0) || (tr > NR - 1) || (tc < 0) || (tc > tr);
    check("mv.ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1; bus.cmd_dir = 3'(dir);
    tick();
    bus.cmd_valid = 0;
    check("mv.strobe", bus.nios_start_qbert, 1);
    check("mv.jump",   bus.qbert_jump, dir);
    check("mv.bad",    bus.bad_jump, oob);
    m_jump = dir; m_bad = oob;
    tick();
    check("mv.strobe_once", bus.nios_start_qbert, 0);
    check("mv.jump_hold",   bus.qbert_jump, dir);
    check("mv.bad_hold",    bus.bad_jump, oob);
    bus.done_move = 1;
    tick();
    bus.done_move = 0;
    tick();
    check("mv.early_rank",  bus.qbert_rank, m_r);
    check("mv.early_ready", bus.cmd_ready, 0);
    tick();
    if (oob) begin
      m_fell = 1;
    end else begin
      m_r = tr; m_c = tc;
      m_vis[tr * (tr + 1) / 2 + tc] = 1;
      m_bad = 0;
      all = 1;
      for (int i = 0; i < NC; i++) all = all & m_vis[i];
      m_level = all;
    end
    check_all("mv");
  endtask

  task automatic try_ignored(input int dir, input string tag);
    bus.cmd_valid = 1; bus.cmd_dir = 3'(dir);
    tick();
    bus.cmd_valid = 0;
    check({tag, ".no_strobe0"}, bus.nios_start_qbert, 0);
    tick();
    check({tag, ".no_strobe1"}, bus.nios_start_qbert, 0);
    check_all(tag);
  endtask

  task automatic do_restart();
    bus.restart = 1;
    tick();
    bus.restart = 0;
    model_reset();
    check_all("restart");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int path [6] = '{3, 3, 2, 4, 2, 4};
    int d;
    bus.restart = 0; bus.cmd_valid = 0; bus.cmd_dir = 0; bus.done_move = 0;
    reset = 1;
    model_reset();
    tick(); tick();
    reset = 0;
    check_all("reset");

    do_move(3);
    check("t1.rank",   bus.qbert_rank, 1);
    check("t1.col",    bus.qbert_col, 1);
    check("t1.colour", bus.top_color, 6'b000101);

    do_restart();
    do_move(1);
    check("t2.fell",  bus.fell, 1);
    check("t2.rank",  bus.qbert_rank, 0);
    check("t2.ready", bus.cmd_ready, 0);
    do_restart();
    check("t2.fell_clr", bus.fell, 0);

    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("t3.level_before", bus.level_done, 0);
      do_move(path[i]);
    end
    check("t3.level",  bus.level_done, 1);
    check("t3.colour", bus.top_color, 6'b111111);
    try_ignored(3, "t3.ignored");

    do_restart();
    try_ignored(0, "ill0");
    try_ignored(7, "ill7");

    do_move(4);
    bus.restart = 1; bus.cmd_valid = 1; bus.cmd_dir = 3;
    tick();
    bus.restart = 0; bus.cmd_valid = 0;
    model_reset();
    check("rc.no_strobe0", bus.nios_start_qbert, 0);
    tick();
    check("rc.no_strobe1", bus.nios_start_qbert, 0);
    check_all("rc");

    bus.cmd_valid = 1; bus.cmd_dir = 3;
    tick();
    bus.cmd_valid = 0;
    check("to.strobe", bus.nios_start_qbert, 1);
    repeat (16) tick();
    check("to.not_yet", bus.timeout_err, 0);
    tick();
    check("to.err",   bus.timeout_err, 1);
    check("to.ready", bus.cmd_ready, 0);
    m_to = 1; m_jump = 3;
    check_all("to");

    bus.done_move = 1;
    tick(); tick();
    do_restart();
    bus.cmd_valid = 1; bus.cmd_dir = 3;
    tick();
    bus.cmd_valid = 0;
    check("held.strobe", bus.nios_start_qbert, 1);
    repeat (17) tick();
    m_to = 1; m_jump = 3;
    check_all("held");
    bus.done_move = 0;
    tick();
    do_restart();

    do_move(3);
    bus.cmd_valid = 1; bus.cmd_dir = 4;
    tick();
    bus.cmd_valid = 0;
    tick();
    #5 reset = 1;
    #1;
    check("ar.rank",   bus.qbert_rank, 0);
    check("ar.col",    bus.qbert_col, 0);
    check("ar.colour", bus.top_color, 6'b000001);
    check("ar.jump",   bus.qbert_jump, 0);
    check("ar.bad",    bus.bad_jump, 0);
    check("ar.start",  bus.nios_start_qbert, 0);
    tick();
    reset = 0;
    model_reset();
    tick();
    check_all("ar");

    for (int i = 0; i < 60; i++) begin
      if (m_fell || m_to) begin
        do_restart();
      end else if (m_level) begin
        try_ignored(3, "rnd.lvl");
        do_restart();
      end else begin
        d = $urandom_range(0, 7);
        if (d >= 1 && d <= 4) do_move(d);
        else                  try_ignored(d, "rnd.ill");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
